// File: rtl/mux_sel_pipe.sv
// Registered NUM_IN-way word selector with a 2-entry in-order output buffer.
// Out-of-range selects return DEFAULT_VAL, raise out_err and bump a saturating counter.
module mux_sel_pipe #(
  parameter int              WIDTH       = 5,
  parameter int              NUM_IN      = 4,
  parameter int              SEL_W       = 2,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              err_count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] tail_data;
  logic [SEL_W-1:0] tail_sel;
  logic             tail_err;
  logic [WIDTH-1:0] pick_data;
  logic             pick_err;
  logic             accept;
  logic             drain;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pick_data = DEFAULT_VAL;
    pick_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        pick_data = in_bus[k*WIDTH +: WIDTH];
        pick_err  = 1'b0;
      end
    end
  end

  // Handshake flags decode straight from the state register.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != TWO);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      out_data  <= '0;
      out_sel   <= '0;
      out_err   <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state    <= ONE;
            out_data <= pick_data;
            out_sel  <= sel;
            out_err  <= pick_err;
          end
        end
        ONE: begin
          if (accept && drain) begin
            out_data <= pick_data;
            out_sel  <= sel;
            out_err  <= pick_err;
          end else if (accept) begin
            state <= TWO;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state    <= ONE;
            out_data <= tail_data;
            out_sel  <= tail_sel;
            out_err  <= tail_err;
          end
        end
        default: state <= EMPTY;
      endcase

      if (accept && pick_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  // NOTE: the second slot is pure storage qualified by state, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == ONE && accept && !drain) begin
      tail_data <= pick_data;
      tail_sel  <= sel;
      tail_err  <= pick_err;
    end
  end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Scoreboard bench: two instances (NUM_IN=4 and NUM_IN=3/DEFAULT_VAL=1F) share stimulus;
// expected entries are queued on accept and compared while they sit at the head.
module tb_mux_sel_pipe;

  typedef struct packed {
    logic [4:0] data;
    logic [1:0] sel;
    logic       err;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] in_bus;
  logic [1:0]  sel;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready4, out_valid4, out_err4;
  logic [4:0]  out_data4;
  logic [1:0]  out_sel4;
  logic [7:0]  err_count4;

  logic        in_ready3, out_valid3, out_err3;
  logic [4:0]  out_data3;
  logic [1:0]  out_sel3;
  logic [7:0]  err_count3;

  int n_vec = 0;
  int n_err = 0;

  entry_t q4[$];
  entry_t q3[$];
  int     occ      = 0;
  int     cnt4     = 0;
  int     cnt3     = 0;
  bit     model_on = 1'b0;
  bit     just_rst = 1'b0;

  always #5 clk = ~clk;

  mux_sel_pipe #(.WIDTH(5), .NUM_IN(4), .SEL_W(2), .DEFAULT_VAL(5'h00)) dut4 (
    .clk(clk), .reset(reset), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready4), .out_data(out_data4), .out_sel(out_sel4), .out_err(out_err4),
    .out_valid(out_valid4), .out_ready(out_ready), .err_count(err_count4)
  );

  mux_sel_pipe #(.WIDTH(5), .NUM_IN(3), .SEL_W(2), .DEFAULT_VAL(5'h1F)) dut3 (
    .clk(clk), .reset(reset), .in_bus(in_bus[14:0]), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready3), .out_data(out_data3), .out_sel(out_sel3), .out_err(out_err3),
    .out_valid(out_valid3), .out_ready(out_ready), .err_count(err_count3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic entry_t model(input logic [19:0] bus, input logic [1:0] s,
                                   input int n, input logic [4:0] dflt);
    entry_t e;
    e.sel = s;
    if (int'(s) < n) begin
      e.data = 5'(bus >> (int'(s) * 5));
      e.err  = 1'b0;
    end else begin
      e.data = dflt;
      e.err  = 1'b1;
    end
    return e;
  endfunction

  // Monitor on the falling edge: inputs and outputs are stable half a cycle from the active edge.
  always @(negedge clk) begin
    bit acc, drn;
    entry_t e;
    if (model_on) begin
      check("valid4", out_valid4, occ > 0);
      check("valid3", out_valid3, occ > 0);
      check("ready4", in_ready4, occ < 2);
      check("ready3", in_ready3, occ < 2);
      check("errcnt4", err_count4, cnt4);
      check("errcnt3", err_count3, cnt3);
      if (just_rst) begin
        check("rst_data4", out_data4, 0);
        check("rst_sel4", out_sel4, 0);
        check("rst_err4", out_err4, 0);
        check("rst_data3", out_data3, 0);
        check("rst_sel3", out_sel3, 0);
        check("rst_err3", out_err3, 0);
      end
      if (occ > 0) begin
        check("head_data4", out_data4, q4[0].data);
        check("head_sel4", out_sel4, q4[0].sel);
        check("head_err4", out_err4, q4[0].err);
        check("head_data3", out_data3, q3[0].data);
        check("head_sel3", out_sel3, q3[0].sel);
        check("head_err3", out_err3, q3[0].err);
      end
    end

    if (reset) begin
      occ = 0;
      q4.delete();
      q3.delete();
      cnt4 = 0;
      cnt3 = 0;
      just_rst = 1'b1;
      model_on = 1'b1;
    end else if (model_on) begin
      just_rst = 1'b0;
      acc = in_valid && (occ < 2);
      drn = (occ > 0) && out_ready;
      if (drn) begin
        e = q4.pop_front();
        e = q3.pop_front();
        occ--;
      end
      if (acc) begin
        e = model(in_bus, sel, 4, 5'h00);
        q4.push_back(e);
        if (e.err && cnt4 < 255) cnt4++;
        e = model(in_bus, sel, 3, 5'h1F);
        q3.push_back(e);
        if (e.err && cnt3 < 255) cnt3++;
        occ++;
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] s, input logic [19:0] bus,
                       input logic rdy);
    in_valid  = v;
    sel       = s;
    in_bus    = bus;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'($urandom), 20'($urandom), 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; sel = '0; in_bus = '0; out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    idle(2);

    // Single transfer with word3..0 = 3,2,1,0 and sel=2.
    drive(1'b1, 2'd2, {5'd3, 5'd2, 5'd1, 5'd0}, 1'b1);
    idle(2);

    // Out-of-range select on the 3-input instance.
    drive(1'b1, 2'd3, 20'h5A5A5, 1'b1);
    idle(2);

    // Fill to TWO under back-pressure, stall a third offer, then release.
    drive(1'b1, 2'd0, 20'h12345, 1'b0);
    drive(1'b1, 2'd1, 20'h6789A, 1'b0);
    drive(1'b1, 2'd2, 20'hBCDEF, 1'b0);
    drive(1'b1, 2'd2, 20'hBCDEF, 1'b0);
    drive(1'b1, 2'd2, 20'hBCDEF, 1'b1);
    drive(1'b1, 2'd2, 20'hBCDEF, 1'b1);
    idle(3);

    // Streaming at full rate.
    for (int i = 0; i < 20; i++) drive(1'b1, 2'(i % 4), 20'($urandom), 1'b1);
    idle(2);

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) drive(1'b1, 2'd3, 20'($urandom), 1'b1);
    idle(2);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 300; i++)
      drive(1'($urandom), 2'($urandom), 20'($urandom), 1'($urandom_range(0, 3) != 0));
    idle(3);

    // Reset while holding two entries with err_count at 4.
    reset = 1'b1;
    drive(1'b0, 2'd0, 20'h0, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 2'd3, 20'($urandom), 1'b1);
    idle(2);
    drive(1'b1, 2'd0, 20'hAAAAA, 1'b0);
    drive(1'b1, 2'd1, 20'h55555, 1'b0);
    reset = 1'b1;
    drive(1'b0, 2'd0, 20'h0, 1'b0);
    reset = 1'b0;
    drive(1'b1, 2'd1, 20'h0A5C3, 1'b0);
    drive(1'b0, 2'd0, 20'h0, 1'b0);
    idle(4);

    check("drained4", q4.size(), 0);
    check("drained3", q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
